// File: rtl/mac_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mac_result_collector                                             |
// | Purpose : Captures each finished/aborted MAC run into a FIFO drained over  |
// |           valid/ready. Define MAC_RES_SAT_EN to clamp out-of-range data.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mac_result_collector #(
  parameter int ACC_W = 22,
  parameter int CNT_W = 9,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mac_busy,
  input  logic                     mac_done,
  input  logic [ACC_W-1:0]         mac_result,
  input  logic [ACC_W-1:0]         mac_acc,
  input  logic [CNT_W-1:0]         mac_count,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_W-1:0]         res_data,
  output logic [CNT_W-1:0]         res_count,
  output logic                     res_abort,
  output logic                     res_sat,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_drop
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;
  localparam int c_ew = OUT_W + CNT_W + 2;
  localparam logic [c_lw-1:0] c_full = c_lw'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_push;
  logic                w_abort;
  logic [ACC_W-1:0]    w_value;
  logic [OUT_W-1:0]    w_data;
  logic                w_sat;
  logic [CNT_W-1:0]    w_cnt;
  logic [c_ew-1:0]     w_entry;

  logic [c_ew-1:0]     r_mem [DEPTH];
  logic [c_aw-1:0]     r_wr_ptr;
  logic [c_aw-1:0]     r_rd_ptr;
  logic [c_lw-1:0]     r_level;
  logic [7:0]          r_drop;
  logic                w_valid;
  logic                w_pop;
  logic                w_accept;
  logic                w_drop;
  logic [c_ew-1:0]     w_head;

  // Run tracking: done has priority over a simultaneous busy fall.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mac_busy) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (mac_done) begin
          w_push       = 1'b1;
          w_state_next = S_IDLE;
        end else if (!mac_busy) begin
          w_push       = 1'b1;
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  assign w_value = w_abort ? mac_acc : mac_result;
  assign w_cnt   = w_abort ? {CNT_W{1'b1}} : mac_count;

  generate
    if (OUT_W < ACC_W) begin : g_reduce
      assign w_sat = |w_value[ACC_W-1:OUT_W];
`ifdef MAC_RES_SAT_EN
      assign w_data = w_sat ? {OUT_W{1'b1}} : w_value[OUT_W-1:0];
`else
      assign w_data = w_value[OUT_W-1:0];
`endif
    end else begin : g_pass
      assign w_sat  = 1'b0;
      assign w_data = w_value[OUT_W-1:0];
    end
  endgenerate

  assign w_entry = {w_abort, w_sat, w_cnt, w_data};

  // A push at full is still accepted when the head leaves in the same cycle.
  assign w_valid  = (r_level != '0);
  assign w_pop    = w_valid && res_ready;
  assign w_accept = w_push && ((r_level != c_full) || w_pop);
  assign w_drop   = w_push && !w_accept;

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (clr_drop)                       r_drop <= '0;
      else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign w_head     = r_mem[r_rd_ptr];
  assign res_valid  = w_valid;
  assign res_data   = w_valid ? w_head[OUT_W-1:0] : '0;
  assign res_count  = w_valid ? w_head[OUT_W +: CNT_W] : '0;
  assign res_sat    = w_valid && w_head[c_ew-2];
  assign res_abort  = w_valid && w_head[c_ew-1];
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_collector.sv
`default_nettype none
// Randomized scoreboard bench for mac_result_collector with directed corner runs.
module tb_mac_result_collector;
  localparam int ACC_W = 22;
  localparam int CNT_W = 9;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0, reset_n = 1'b0;
  logic mac_busy = 1'b0, mac_done = 1'b0, res_ready = 1'b0, clr_drop = 1'b0;
  logic [ACC_W-1:0] mac_result = '0, mac_acc = '0;
  logic [CNT_W-1:0] mac_count = '0;
  logic res_valid, res_abort, res_sat;
  logic [OUT_W-1:0] res_data;
  logic [CNT_W-1:0] res_count;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] drop_cnt;

  int n_checks = 0, n_fail = 0;
  logic ready_rand = 1'b0, ready_force = 1'b0;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             sat;
  } entry_t;

  entry_t exp_q[$];
  int mdl_level = 0, mdl_drop = 0;
  bit mdl_run = 1'b0;

  always #5 clk = ~clk;

  mac_result_collector #(.ACC_W(ACC_W), .CNT_W(CNT_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .mac_busy(mac_busy), .mac_done(mac_done),
    .mac_result(mac_result), .mac_acc(mac_acc), .mac_count(mac_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_count(res_count), .res_abort(res_abort), .res_sat(res_sat),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .clr_drop(clr_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic entry_t make_entry(input int unsigned val, input int unsigned cnt, input bit ab);
    entry_t e;
    e.abort = ab;
    e.count = CNT_W'(cnt);
    e.sat   = (val >= (32'd1 << OUT_W));
    e.data  = OUT_W'(val % (32'd1 << OUT_W));
`ifdef MAC_RES_SAT_EN
    if (e.sat) e.data = '1;
`endif
    return e;
  endfunction

  // Reference model: one run at a time, FIFO of DEPTH slots, saturating drop counter.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_level = 0;
      mdl_drop  = 0;
      mdl_run   = 1'b0;
      exp_q.delete();
    end else begin
      bit     have;
      bit     pop;
      bit     acc;
      entry_t e;
      have = 1'b0;
      e    = '0;
      if (!mdl_run) begin
        mdl_run = mac_busy;
      end else if (mac_done) begin
        have = 1'b1; e = make_entry(mac_result, mac_count, 1'b0); mdl_run = 1'b0;
      end else if (!mac_busy) begin
        have = 1'b1; e = make_entry(mac_acc, (1 << CNT_W) - 1, 1'b1); mdl_run = 1'b0;
      end
      pop = res_ready && (mdl_level > 0);
      acc = have && ((mdl_level < DEPTH) || pop);
      if (acc) exp_q.push_back(e);
      if (clr_drop) mdl_drop = 0;
      else if (have && !acc && mdl_drop < 255) mdl_drop++;
      mdl_level = mdl_level + int'(acc) - int'(pop);
    end
  end

  // Monitor: compares the presented head against the scoreboard and retires it on handshake.
  always @(negedge clk) begin
    check("fifo_level", 32'(fifo_level), mdl_level);
    check("drop_cnt", 32'(drop_cnt), mdl_drop);
    check("res_valid", 32'(res_valid), 32'(mdl_level > 0));
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_entry: got data %0h, expected no entry (t=%0t)", res_data, $time);
      end else begin
        check("res_data", 32'(res_data), 32'(exp_q[0].data));
        check("res_count", 32'(res_count), 32'(exp_q[0].count));
        check("res_abort", 32'(res_abort), 32'(exp_q[0].abort));
        check("res_sat", 32'(res_sat), 32'(exp_q[0].sat));
        if (res_ready) void'(exp_q.pop_front());
      end
    end else begin
      check("empty_outputs", 32'({res_data, res_count, res_abort, res_sat}), 32'd0);
    end
  end

  always @(posedge clk) begin
    #3;
    res_ready = ready_rand ? 1'($urandom) : ready_force;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: done while busy, 1: abort, 2: done with busy falling together.
  task automatic run(input int kind, input logic [ACC_W-1:0] val, input logic [CNT_W-1:0] cnt,
                     input int len, input bit pop_at_capture);
    mac_busy = 1'b1;
    mac_acc  = ACC_W'($urandom);
    tick();
    repeat (len) begin
      mac_acc    = ACC_W'($urandom);
      mac_result = ACC_W'($urandom);
      tick();
    end
    if (pop_at_capture) ready_force = 1'b1;
    case (kind)
      0:       begin mac_done = 1'b1; mac_result = val; mac_count = cnt; end
      1:       begin mac_busy = 1'b0; mac_acc = val; end
      default: begin mac_done = 1'b1; mac_busy = 1'b0; mac_result = val; mac_count = cnt; end
    endcase
    tick();
    mac_done    = 1'b0;
    mac_busy    = 1'b0;
    mac_result  = ACC_W'($urandom);
    mac_acc     = ACC_W'($urandom);
    mac_count   = CNT_W'($urandom);
    ready_force = 1'b0;
  endtask

  task automatic drain();
    ready_force = 1'b1;
    repeat (7) tick();
    ready_force = 1'b0;
    tick();
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    reset_n = 1'b1;
    tick();

    run(0, 22'h000123, 9'd50, 2, 1'b0);
    #1;
    check("basic_valid", 32'(res_valid), 32'd1);
    check("basic_data", 32'(res_data), 32'h0123);
    check("basic_count", 32'(res_count), 32'd50);
    check("basic_abort_sat", 32'({res_abort, res_sat}), 32'd0);
    drain();

    run(0, 22'h012345, 9'd7, 1, 1'b0);
    #1;
`ifdef MAC_RES_SAT_EN
    check("sat_data", 32'(res_data), 32'hFFFF);
`else
    check("sat_data", 32'(res_data), 32'h2345);
`endif
    check("sat_flag", 32'(res_sat), 32'd1);
    drain();

    run(1, 22'h000040, 9'd0, 3, 1'b0);
    #1;
    check("abort_data", 32'(res_data), 32'h0040);
    check("abort_count", 32'(res_count), 32'h1FF);
    check("abort_flag", 32'(res_abort), 32'd1);
    drain();

    run(2, 22'h000077, 9'd3, 1, 1'b0);
    tick();
    check("same_cycle_level", 32'(fifo_level), 32'd1);
    check("same_cycle_abort", 32'(res_abort), 32'd0);
    check("same_cycle_data", 32'(res_data), 32'h0077);
    drain();

    for (int i = 0; i < 6; i++) begin
      run(0, ACC_W'(i + 1), CNT_W'(i), 0, 1'b0);
      tick();
    end
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_drop", 32'(drop_cnt), 32'd2);
    run(0, 22'h000AAA, 9'd9, 0, 1'b1);
    #1;
    check("full_pop_level", 32'(fifo_level), 32'd4);
    check("full_pop_drop", 32'(drop_cnt), 32'd2);
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    tick(); tick();
    check("three_level", 32'(fifo_level), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_valid", 32'(res_valid), 32'd0);
    check("async_rst_drop", 32'(drop_cnt), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 262; i++) run(1, ACC_W'(i), 9'd0, 0, 1'b0);
    tick();
    check("drop_saturate", 32'(drop_cnt), 32'd255);
    clr_drop = 1'b1;
    run(1, 22'h000001, 9'd0, 0, 1'b0);
    clr_drop = 1'b0;
    #1;
    check("clr_wins", 32'(drop_cnt), 32'd0);
    drain();

    ready_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [ACC_W-1:0] v;
      if ($urandom_range(0, 5) == 0) begin
        mac_done   = 1'b1;
        mac_result = ACC_W'($urandom);
        tick();
        mac_done = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) v = ACC_W'($urandom_range(0, 65535));
      else                           v = ACC_W'($urandom);
      clr_drop = ($urandom_range(0, 15) == 0);
      run($urandom_range(0, 2), v, CNT_W'($urandom), $urandom_range(0, 3), 1'b0);
      clr_drop = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    ready_rand  = 1'b0;
    ready_force = 1'b1;
    repeat (10) tick();
    check("final_level", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
